score_text_decoder: RTL

Inverse of the score-to-text path: takes a packed 6-bit-per-character text word, as driven to the text display, and recovers the binary score. Character fields are display glyph indices; digits 0-9 occupy indices 53-62. Used to load a saved or high-score text back into the cumulative-score datapath and to cross-check the displayed score against the binary counter. Conversion is sequential, one digit per clock, using shift-add ×10 accumulation with no hardware multiplier.

---
 rtl/score_text_pkg.sv | 24 ++
 rtl/score_text_decoder_glyph.sv | 25 ++
 rtl/score_text_decoder.sv | 125 ++++++++++++
 3 files changed

// File: rtl/score_text_pkg.sv
// Shared definitions for the score text path: glyph constants, the
// decoder FSM state type and the field-extract helper that fixes field order
// for both the encoder and the decoder.
package score_text_pkg;

  localparam int ZERO_INDEX  = 53;
  localparam int CHAR_W      = 6;
  localparam int DIGIT_COUNT = 10;
  localparam int TEXT_MAX_W  = 64;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_e;

  // Field k of a packed text word; field 0 sits in the least significant bits
  // and carries the most significant decimal digit.
  function automatic logic [CHAR_W-1:0] get_field(input logic [TEXT_MAX_W-1:0] text,
                                                  input int unsigned k);
    return text[CHAR_W*k +: CHAR_W];
  endfunction

endpackage

// File: rtl/score_text_decoder_glyph.sv
// Maps one display glyph index to a decimal digit. Anything outside the
// digit glyph range reports is_digit_o=0 and a digit of zero.
module glyph_to_digit
  import score_text_pkg::*;
#(
  parameter int CHAR_W     = 6,
  parameter int ZERO_INDEX = 53
) (
  input  logic [CHAR_W-1:0] glyph_i,
  output logic [3:0]        digit_o,
  output logic              is_digit_o
);

  localparam logic [CHAR_W:0] LO_G = (CHAR_W+1)'(ZERO_INDEX);
  localparam logic [CHAR_W:0] HI_G = (CHAR_W+1)'(ZERO_INDEX + DIGIT_COUNT - 1);

  logic [CHAR_W:0] glyph_ext;
  logic [3:0]      offset;

  assign glyph_ext  = {1'b0, glyph_i};
  assign is_digit_o = (glyph_ext >= LO_G) && (glyph_ext <= HI_G);
  assign offset     = 4'(glyph_ext - LO_G);
  assign digit_o    = is_digit_o ? offset : 4'd0;

endmodule

// File: rtl/score_text_decoder.sv
// Converts a packed glyph-index text word back into a binary score, one
// digit per clock, using acc*10 = (acc<<3)+(acc<<1) accumulation with
// saturation at the output width.
module score_text_decoder
  import score_text_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter int CHAR_W     = 6,
  parameter int OUT_W      = 10,
  parameter int ZERO_INDEX = 53
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic [NUM_DIGITS*CHAR_W-1:0] text_in,
  output logic                         busy,
  output logic                         ready,
  output logic [OUT_W-1:0]             value,
  output logic                         bad_char,
  output logic                         overflow
);

  localparam int TEXT_W = NUM_DIGITS * CHAR_W;
  localparam int ACC_W  = OUT_W + 4;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [OUT_W-1:0] SAT_VAL  = {OUT_W{1'b1}};
  localparam logic [ACC_W-1:0] SAT_ACC  = {{(ACC_W-OUT_W){1'b0}}, SAT_VAL};

  state_e              state_q;
  logic [TEXT_W-1:0]   text_q;
  logic [IDX_W-1:0]    idx_q;
  logic [OUT_W-1:0]    acc_q;
  logic                err_q;
  logic                ovf_q;
  logic                busy_q;
  logic                ready_q;
  logic [OUT_W-1:0]    value_q;
  logic                bad_char_q;
  logic                overflow_q;

  logic [TEXT_MAX_W-1:0] text_ext;
  logic [CHAR_W-1:0]     glyph;
  logic [3:0]            digit;
  logic                  is_digit;
  logic [ACC_W-1:0]      acc_sum;
  logic                  sat;
  logic [OUT_W-1:0]      acc_d;

  assign text_ext = TEXT_MAX_W'(text_q);
  assign glyph    = get_field(text_ext, 32'(idx_q));

  glyph_to_digit #(
    .CHAR_W     (CHAR_W),
    .ZERO_INDEX (ZERO_INDEX)
  ) u_glyph_to_digit (
    .glyph_i    (glyph),
    .digit_o    (digit),
    .is_digit_o (is_digit)
  );

  // Next accumulator value: acc*10 + digit, clamped to the output range.
  always_comb begin
    acc_sum = (ACC_W'(acc_q) << 3) + (ACC_W'(acc_q) << 1) + ACC_W'(digit);
    sat     = (acc_sum > SAT_ACC);
    acc_d   = sat ? SAT_VAL : acc_sum[OUT_W-1:0];
  end

  // Conversion FSM with its counter, accumulator and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      text_q     <= '0;
      idx_q      <= '0;
      acc_q      <= '0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      value_q    <= '0;
      bad_char_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            text_q  <= text_in;
            acc_q   <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
            state_q <= CONV;
          end
        end
        CONV: begin
          busy_q <= 1'b1;
          acc_q  <= acc_d;
          err_q  <= err_q | ~is_digit;
          ovf_q  <= ovf_q | sat;
          idx_q  <= idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          value_q    <= err_q ? '0 : acc_q;
          bad_char_q <= err_q;
          overflow_q <= ovf_q & ~err_q;
          ready_q    <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign ready    = ready_q;
  assign value    = value_q;
  assign bad_char = bad_char_q;
  assign overflow = overflow_q;

endmodule
